cardinal_nic: RTL and testbench
===============================

Name: cardinal_nic

Overview:
- Network interface controller between one four_stage_processor node and its mesh router port.
- One instance per node in the 4-node CMP.
- Processor side: memory-mapped, 2-bit address; driven by the processor's NIC-decoded memory strobes.
- Router side: one-entry input channel buffer and one-entry output channel buffer, with send/ready handshakes and virtual-channel polarity gating.

Parameters:
- DATA_WIDTH, 64, packet and processor data width (bit 0 = MSB; bit 0 of packet = VC bit).
- ADDR_IN_BUF, 2'b00, read address of input channel buffer.
- ADDR_IN_STAT, 2'b01, read address of input channel status.
- ADDR_OUT_BUF, 2'b10, write address of output channel buffer.
- ADDR_OUT_STAT, 2'b11, read address of output channel status.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  processor register select [0:1].
- d_in  input  64  processor write data [0:63].
- d_out  output  64  processor read data [0:63].
- nicEn  input  1  processor access strobe.
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn).
- net_si  input  1  router sending packet into NIC.
- net_ri  input  1  router ready to accept packet from NIC.
- net_di  input  64  packet from router.
- net_so  output  1  NIC sending packet to router.
- net_ro  output  1  NIC ready to accept packet from router.
- net_do  output  64  packet to router.
- net_polarity  input  1  router current cycle polarity.

Behaviour:
- Reset (async, active-high): in_buf=0, in_full=0, out_buf=0, out_full=0.
  - Resulting outputs: d_out=0, net_so=0, net_ro=1, net_do=0.
  - Reset mid-transfer discards both buffers immediately.
- Input channel:
  - net_ro = ~in_full (combinational).
  - On rising clk with net_si & net_ro: in_buf <= net_di, in_full <= 1.
  - net_si while in_full is ignored (router protocol violation; no state change).
- Processor read of input buffer: nicEn & ~nicWrEn & addr==ADDR_IN_BUF.
  - d_out = in_buf combinationally, same cycle.
  - At the clock edge: in_full <= 0, in_buf retained.
  - Read while in_full=0 returns stale in_buf; no state change.
- Output channel write: nicEn & nicWrEn & addr==ADDR_OUT_BUF & ~out_full.
  - At the edge: out_buf <= d_in, out_full <= 1.
  - Write while out_full=1 is dropped silently; software must poll status first.
  - Writes to any other address are ignored.
- Injection:
  - net_so = out_full & net_ri & (net_polarity == out_buf[0]) (combinational).
  - net_do = out_buf always.
  - At the edge with net_so=1: out_full <= 0.
- Processor write and injection in the same cycle: the write is dropped, because out_full was 1 during that cycle.
- Status reads (nicEn & ~nicWrEn):
  - ADDR_IN_STAT: d_out[63] = in_full, other bits 0.
  - ADDR_OUT_STAT: d_out[63] = out_full, other bits 0.
- d_out = 0 whenever nicEn=0, nicWrEn=1, or addr==ADDR_OUT_BUF.
- Latency:
  - Router to readable by processor: 1 clk.
  - Processor write to net_so possible: 1 clk.
  - Back-to-back throughput: one packet per 2 cycles per direction.
- Both buffers are independent: simultaneous receive, read, write and send are all legal in one cycle.

Optional Feature:
- Macro: CARDINAL_NIC_STATS_EN.
- When defined:
  - Adds 16-bit rx_cnt (increments on each accepted net_di) and tx_cnt (increments on each net_so cycle). Both wrap 16'hFFFF -> 0 and reset to 0.
  - ADDR_IN_STAT read returns rx_cnt in d_out[32:47].
  - ADDR_OUT_STAT read returns tx_cnt in d_out[32:47].
  - Bit 63 is unchanged.
- When undefined: those bits read 0 and no counter flops exist.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with both buffers full -> net_ro=1, net_so=0, status reads d_out=64'h0 immediately.
- Receive: net_si=1, net_di=64'h8000_0000_DEAD_BEEF for 1 clk -> net_ro=0 next cycle, IN_STAT read=64'h1.
  - Then IN_BUF read -> d_out=64'h8000_0000_DEAD_BEEF and net_ro=1 next cycle.
- Inject with polarity: write out_buf=64'h8000_0000_0000_0042 with net_ri=1.
  - net_polarity=0 -> net_so stays 0.
  - net_polarity=1 -> net_so=1 for exactly one cycle with net_do=64'h8000_0000_0000_0042, then OUT_STAT=0.
- Backpressure: out_full=1, net_ri=0; second write 64'h1234 -> dropped.
  - After net_ri=1 (matching polarity) the first packet is sent, not 64'h1234.
- Concurrency: same cycle receive of 64'h5, IN_BUF read of previous packet 64'h7, and OUT_BUF write of 64'h9 -> d_out=64'h7; next cycle in_buf=64'h5 (in_full=1), out_buf=64'h9 (out_full=1).
- Stats (CARDINAL_NIC_STATS_EN): 3 receives and 2 sends -> IN_STAT d_out[32:47]=16'd3, OUT_STAT=16'd2.
  - Preload to 16'hFFFF via 65535 sends; one more send -> 16'h0000.

Source files
------------

// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_nic
// Purpose  : Memory-mapped NIC between a processor node and its mesh router
//            port: one-entry input/output buffers with VC polarity gating.
//            Optional counters: define CARDINAL_NIC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cardinal_nic #(
  parameter int         DATA_WIDTH    = 64,
  parameter logic [0:1] ADDR_IN_BUF   = 2'b00,
  parameter logic [0:1] ADDR_IN_STAT  = 2'b01,
  parameter logic [0:1] ADDR_OUT_BUF  = 2'b10,
  parameter logic [0:1] ADDR_OUT_STAT = 2'b11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  input  logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  output logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  // Counter field sits at big-endian bits [32:47] of a 64-bit word.
  localparam int CNT_MSB = DATA_WIDTH - 32;
  localparam int CNT_LSB = DATA_WIDTH - 17;

  logic [0:DATA_WIDTH-1] r_in_buf;
  logic [0:DATA_WIDTH-1] r_out_buf;
  logic                  r_in_full;
  logic                  r_out_full;

  logic                  w_rd;
  logic                  w_rd_in_buf;
  logic                  w_wr_out_buf;
  logic                  w_rx_accept;
  logic                  w_tx_send;
  logic [15:0]           w_rx_cnt;
  logic [15:0]           w_tx_cnt;

  assign w_rd         = nicEn & ~nicWrEn;
  assign w_rd_in_buf  = w_rd & (addr == ADDR_IN_BUF);
  assign w_wr_out_buf = nicEn & nicWrEn & (addr == ADDR_OUT_BUF) & ~r_out_full;

  assign net_ro       = ~r_in_full;
  assign w_rx_accept  = net_si & ~r_in_full;
  assign w_tx_send    = r_out_full & net_ri & (net_polarity == r_out_buf[0]);
  assign net_so       = w_tx_send;
  assign net_do       = r_out_buf;

  // An accept only happens when empty, so it always wins over a same-cycle read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_rx_accept) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd_in_buf) begin
      r_in_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_wr_out_buf) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end else if (w_tx_send) begin
      r_out_full <= 1'b0;
    end
  end

`ifdef CARDINAL_NIC_STATS_EN
  logic [15:0] r_rx_cnt;
  logic [15:0] r_tx_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_cnt <= 16'h0;
      r_tx_cnt <= 16'h0;
    end else begin
      if (w_rx_accept) r_rx_cnt <= r_rx_cnt + 16'd1;
      if (w_tx_send)   r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  assign w_rx_cnt = r_rx_cnt;
  assign w_tx_cnt = r_tx_cnt;
`else
  assign w_rx_cnt = 16'h0;
  assign w_tx_cnt = 16'h0;
`endif

  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        ADDR_IN_BUF: d_out = r_in_buf;
        ADDR_IN_STAT: begin
          d_out[DATA_WIDTH-1]     = r_in_full;
          d_out[CNT_MSB:CNT_LSB]  = w_rx_cnt;
        end
        ADDR_OUT_STAT: begin
          d_out[DATA_WIDTH-1]     = r_out_full;
          d_out[CNT_MSB:CNT_LSB]  = w_tx_cnt;
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// Testbench for cardinal_nic: directed stimulus with queued expectations
// checked by a negedge monitor.
module tb_cardinal_nic;

  localparam logic [0:1] A_IN_BUF   = 2'b00;
  localparam logic [0:1] A_IN_STAT  = 2'b01;
  localparam logic [0:1] A_OUT_BUF  = 2'b10;
  localparam logic [0:1] A_OUT_STAT = 2'b11;
`ifdef CARDINAL_NIC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;

  logic [0:63] rd_q[$];
  string       rd_n[$];
  logic [0:63] tx_q[$];
  logic        ro_q[$];
  logic        chk_ro   = 1'b0;
  logic        chk_idle = 1'b0;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  function automatic logic [0:63] stat(input logic full, input int cnt);
    logic [0:63] v;
    logic [15:0] c;
    c        = cnt[15:0];
    v        = '0;
    v[63]    = full;
    v[32:47] = STATS ? c : 16'h0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    nicEn    = 1'b0;
    nicWrEn  = 1'b0;
    net_si   = 1'b0;
    chk_ro   = 1'b0;
    chk_idle = 1'b0;
  endtask

  task automatic rd(input logic [0:1] a, input logic [0:63] e, input string n);
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = a;
    rd_q.push_back(e);
    rd_n.push_back(n);
  endtask

  task automatic wr(input logic [0:1] a, input logic [0:63] data);
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    addr    = a;
    d_in    = data;
  endtask

  task automatic rx(input logic [0:63] data, input bit accepted);
    net_si = 1'b1;
    net_di = data;
    if (accepted) rx_cnt++;
  endtask

  task automatic exp_ro(input logic v);
    chk_ro = 1'b1;
    ro_q.push_back(v);
  endtask

  task automatic exp_tx(input logic [0:63] data);
    tx_q.push_back(data);
    tx_cnt++;
  endtask

  task automatic exp_idle();
    chk_idle = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [0:63] e;
    logic        eb;
    string       n;
    if (chk_ro) begin
      eb = ro_q.pop_front();
      checks++;
      if (net_ro !== eb) begin
        failures++;
        $display("FAIL net_ro: got %0b want %0b at %0t", net_ro, eb, $time);
      end
    end
    if (chk_idle) begin
      checks++;
      if (net_so !== 1'b0) begin
        failures++;
        $display("FAIL net_so_idle: got %0b want 0 at %0t", net_so, $time);
      end
    end
    if (nicEn === 1'b1 && nicWrEn === 1'b0) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got d_out=%h want none at %0t", d_out, $time);
      end else begin
        e = rd_q.pop_front();
        n = rd_n.pop_front();
        if (d_out !== e) begin
          failures++;
          $display("FAIL %s: got d_out=%h want %h at %0t", n, d_out, e, $time);
        end
      end
    end
    if (net_so === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_send: got net_do=%h want no send at %0t", net_do, $time);
      end else begin
        e = tx_q.pop_front();
        if (net_do !== e) begin
          failures++;
          $display("FAIL send_data: got net_do=%h want %h at %0t", net_do, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_ri = 1'b0; net_di = '0; net_polarity = 1'b0;

    // Power-on reset state
    tick(); rd(A_IN_STAT, 64'h0, "rst_in_stat"); exp_ro(1'b1); exp_idle();
    tick(); rd(A_OUT_STAT, 64'h0, "rst_out_stat"); exp_idle();
    tick(); reset = 1'b0;

    // Receive, status, read, stale read, zero-read address
    tick(); rx(64'h8000_0000_DEAD_BEEF, 1'b1); exp_ro(1'b1);
    tick(); exp_ro(1'b0); rd(A_IN_STAT, stat(1'b1, rx_cnt), "rx_in_stat");
    tick(); exp_ro(1'b0); rd(A_IN_BUF, 64'h8000_0000_DEAD_BEEF, "rx_in_buf");
    tick(); exp_ro(1'b1); rd(A_IN_STAT, stat(1'b0, rx_cnt), "rx_in_stat_clr");
    tick(); exp_ro(1'b1); rd(A_IN_BUF, 64'h8000_0000_DEAD_BEEF, "stale_in_buf");
    tick(); rd(A_OUT_BUF, 64'h0, "rd_out_buf_addr_zero");

    // Injection gated by polarity
    net_ri = 1'b1; net_polarity = 1'b0;
    tick(); wr(A_OUT_BUF, 64'h8000_0000_0000_0042); exp_idle();
    tick(); exp_idle(); rd(A_OUT_STAT, stat(1'b1, tx_cnt), "inj_out_stat_full");
    tick(); exp_idle();
    tick(); net_polarity = 1'b1; exp_tx(64'h8000_0000_0000_0042);
    tick(); exp_idle(); rd(A_OUT_STAT, stat(1'b0, tx_cnt), "inj_out_stat_empty");

    // Backpressure: second write while full is dropped
    net_ri = 1'b0;
    tick(); wr(A_OUT_BUF, 64'h8000_0000_0000_00AA);
    tick(); wr(A_OUT_BUF, 64'h0000_0000_0000_1234); exp_idle();
    tick(); exp_idle(); rd(A_OUT_STAT, stat(1'b1, tx_cnt), "bp_out_full");
    tick(); net_ri = 1'b1; exp_tx(64'h8000_0000_0000_00AA);
    tick(); exp_idle(); rd(A_OUT_STAT, stat(1'b0, tx_cnt), "bp_out_empty");

    // Write in the same cycle as a send is dropped
    tick(); wr(A_OUT_BUF, 64'h8000_0000_0000_00BB); exp_idle();
    tick(); wr(A_OUT_BUF, 64'h8000_0000_0000_00CC); exp_tx(64'h8000_0000_0000_00BB);
    tick(); exp_idle(); rd(A_OUT_STAT, stat(1'b0, tx_cnt), "wr_during_send_dropped");

    // VC bit 0 packet waits for polarity 0
    tick(); wr(A_OUT_BUF, 64'h0000_0000_0000_0055); exp_idle();
    tick(); exp_idle();
    tick(); net_polarity = 1'b0; exp_tx(64'h0000_0000_0000_0055);
    tick(); exp_idle();

    // Concurrency: receive + stale read + send in one cycle
    net_ri = 1'b0;
    tick(); rx(64'h7, 1'b1); wr(A_OUT_BUF, 64'h9);
    tick(); exp_ro(1'b0); rd(A_IN_BUF, 64'h7, "conc_rd7");
    tick(); exp_ro(1'b1); rx(64'h5, 1'b1); rd(A_IN_BUF, 64'h7, "conc_stale7");
            net_ri = 1'b1; exp_tx(64'h9);
    tick(); net_ri = 1'b0; exp_ro(1'b0); rd(A_IN_STAT, stat(1'b1, rx_cnt), "conc_in_stat");
    tick(); exp_ro(1'b0); rx(64'h0BAD, 1'b0);
    tick(); rd(A_IN_BUF, 64'h5, "conc_rd5_not_overwritten");
    tick(); rd(A_OUT_STAT, stat(1'b0, tx_cnt), "conc_out_stat");

    // Asynchronous reset mid-cycle with both buffers full
    tick(); rx(64'h3, 1'b1); wr(A_OUT_BUF, 64'h11);
    tick(); exp_ro(1'b0); rd(A_OUT_STAT, stat(1'b1, tx_cnt), "pre_rst_out_full");
    tick(); net_ri = 1'b1; net_polarity = 1'b0;
            rd(A_IN_STAT, 64'h0, "async_rst_in_stat"); exp_ro(1'b1); exp_idle();
            #2 reset = 1'b1; rx_cnt = 0; tx_cnt = 0;
    tick(); rd(A_OUT_STAT, 64'h0, "async_rst_out_stat"); exp_idle();
    tick(); reset = 1'b0; net_ri = 1'b0;

    // Normal operation after reset
    tick(); rx(64'hA, 1'b1);
    tick(); rd(A_IN_BUF, 64'hA, "post_rst_rx");
    tick(); rd(A_IN_STAT, stat(1'b0, rx_cnt), "post_rst_in_stat");
    tick();
    tick();

    checks++;
    if (tx_q.size() != 0) begin
      failures++;
      $display("FAIL pending_sends: got %0d outstanding want 0", tx_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      failures++;
      $display("FAIL pending_reads: got %0d outstanding want 0", rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
